// File: rtl/aemb_dwb_timer_if.sv
// rtl/aemb_dwb_timer_if.sv - dwb data-bus signal bundle between aeMB master and timer slave
interface aemb_dwb_timer_if #(
  parameter int AW = 8
);
  logic          stb;
  logic          wre;
  logic [3:0]    sel;
  logic [AW-1:2] adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack;

  modport master (output stb, wre, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input stb, wre, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/aemb_dwb_timer.sv
// rtl/aemb_dwb_timer.sv - dwb slave with timer/interrupt registers and programmable wait states
module aemb_dwb_timer #(
  parameter int AW = 8,
  parameter int WS = 0,
  parameter int CW = 32
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  aemb_dwb_timer_if.slave dwb,
  output logic            sys_int_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_RCV} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          commit;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cmp_q, cmp_d;
  logic [2:0]    ctl_q, ctl_d;   // {AUTO, IE, EN}
  logic          pend_q, pend_d;
  logic          int_q;
  logic [31:0]   dat_q;

  logic [31:0]   wmask;
  logic [31:0]   rdata;
  logic [31:0]   cnt32, cmp32;
  logic          match;
  logic          wr_cnt, wr_cmp, wr_ctl, wr_sts;
  logic          unused_adr;

  // Only adr[3:2] selects a register; the rest of the word address is don't-care.
  assign unused_adr = ^dwb.adr;

  assign cnt32  = 32'(cnt_q);
  assign cmp32  = 32'(cmp_q);
  assign wmask  = {{8{dwb.sel[3]}}, {8{dwb.sel[2]}}, {8{dwb.sel[1]}}, {8{dwb.sel[0]}}};
  assign match  = ctl_q[0] && (cnt_q == cmp_q);
  assign wr_cnt = commit && dwb.wre && (dwb.adr[3:2] == 2'd0);
  assign wr_cmp = commit && dwb.wre && (dwb.adr[3:2] == 2'd1);
  assign wr_ctl = commit && dwb.wre && (dwb.adr[3:2] == 2'd2);
  assign wr_sts = commit && dwb.wre && (dwb.adr[3:2] == 2'd3);

  assign dwb.ack   = (state_q == ST_ACK);
  assign dwb.dat_r = dat_q;
  assign sys_int_o = int_q;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Bus handshake: IDLE -> (WAIT) -> ACK -> RCV; commit marks the edge entering ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dwb.stb) begin
          if (WS > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = 4'(WS - 1);
          end else begin
            state_d = ST_ACK;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
          commit  = 1'b1;
        end
      end
      ST_ACK:  state_d = ST_RCV;
      ST_RCV:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register read mux; unused bits and bits above CW read as zero.
  always_comb begin
    rdata = 32'd0;
    case (dwb.adr[3:2])
      2'd0: rdata = cnt32;
      2'd1: rdata = cmp32;
      2'd2: rdata = {29'd0, ctl_q};
      2'd3: rdata = {31'd0, pend_q};
      default: rdata = 32'd0;
    endcase
  end

  // Timer next state; a bus write to a register overrides counter effects on it, PEND set beats clear.
  always_comb begin
    cnt_d  = cnt_q;
    cmp_d  = cmp_q;
    ctl_d  = ctl_q;
    pend_d = pend_q;
    if (ctl_q[0]) begin
      if (!match)        cnt_d = cnt_q + 1'b1;
      else if (ctl_q[2]) cnt_d = '0;
      else               ctl_d[0] = 1'b0;
    end
    if (match)                                 pend_d = 1'b1;
    else if (wr_sts && dwb.sel[0] && dwb.dat_w[0]) pend_d = 1'b0;
    if (wr_cnt) cnt_d = CW'(merge(cnt32, dwb.dat_w, wmask));
    if (wr_cmp) cmp_d = CW'(merge(cmp32, dwb.dat_w, wmask));
    if (wr_ctl) ctl_d = 3'(merge({29'd0, ctl_q}, dwb.dat_w, wmask));
  end

  // State, timer registers, read-data capture and interrupt level.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      cnt_q   <= '0;
      cmp_q   <= '1;
      ctl_q   <= 3'd0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctl_q   <= ctl_d;
      pend_q  <= pend_d;
      int_q   <= pend_q & ctl_q[1];
      dat_q   <= (commit && !dwb.wre) ? rdata : 32'd0;
    end
  end

endmodule
